// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared FSM state type and bit-period helper for the UART transceiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_transceiver_if.sv
// ============================================================================
// Module : uart_transceiver_if
// Brief  : Serial pins plus RX/TX byte handshake of the UART transceiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_transceiver_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic                    uart_rx_break;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_txd;
  logic                    uart_tx_en;
  logic                    uart_tx_busy;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;

  // master = board/system side, slave = the transceiver
  modport master (
    output uart_rxd, uart_rx_en, uart_tx_en, uart_tx_data,
    input  uart_rx_valid, uart_rx_break, uart_rx_data, uart_txd, uart_tx_busy
  );

  modport slave (
    input  uart_rxd, uart_rx_en, uart_tx_en, uart_tx_data,
    output uart_rx_valid, uart_rx_break, uart_rx_data, uart_txd, uart_tx_busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module : uart_bit_timer
// Brief  : Loadable bit-period down-counter; tick marks the last cycle of a load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_bit_timer #(
  parameter int CYCLES = 2604,
  parameter int HALF   = 1302
) (
  input  logic clk1,
  input  logic rst,
  input  logic load_half_i,
  input  logic load_full_i,
  output logic tick_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter parks at zero when not reloaded, so tick never repeats on its own
  always_comb begin
    cnt_d = cnt_q;
    if (load_full_i) begin
      cnt_d = CW'(CYCLES);
    end else if (load_half_i) begin
      cnt_d = CW'(HALF);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CW'(1));

endmodule

`default_nettype wire

// File: rtl/uart_transceiver.sv
// ============================================================================
// Module : uart_transceiver
// Brief  : Full-duplex 8N1 UART with independent RX and TX state machines.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk1,
  input  logic              rst,
  uart_transceiver_if.slave bus
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);
  localparam int STOP_W         = $clog2(STOP_BITS + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  // ---------------- receive path ----------------
  logic [1:0]              rx_sync_q;
  logic                    rx_prev_q;
  uart_state_t             rx_state_q, rx_state_d;
  logic [IDX_W-1:0]        rx_idx_q, rx_idx_d;
  logic [PAYLOAD_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [PAYLOAD_BITS-1:0] rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_break_q, rx_break_d;
  logic                    rx_load_half, rx_load_full, rx_tick;
  logic                    w_rx_bit;

  assign w_rx_bit = rx_sync_q[1];

  uart_bit_timer #(.CYCLES(CYCLES_PER_BIT), .HALF(HALF_BIT)) u_rx_timer (
    .clk1        (clk1),
    .rst         (rst),
    .load_half_i (rx_load_half),
    .load_full_i (rx_load_full),
    .tick_o      (rx_tick)
  );

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_break_d   = 1'b0;
    rx_load_half = 1'b0;
    rx_load_full = 1'b0;
    if (!bus.uart_rx_en) begin
      rx_state_d = IDLE;
    end else begin
      case (rx_state_q)
        IDLE: begin
          // Falling edge requires a prior high sample, so a held-low line never restarts
          if (rx_prev_q && !w_rx_bit) begin
            rx_state_d   = START;
            rx_idx_d     = '0;
            rx_load_half = 1'b1;
          end
        end
        START: begin
          if (rx_tick) begin
            if (!w_rx_bit) begin
              rx_state_d   = DATA;
              rx_load_full = 1'b1;
            end else begin
              rx_state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (rx_tick) begin
            rx_shift_d   = {w_rx_bit, rx_shift_q[PAYLOAD_BITS-1:1]};
            rx_load_full = 1'b1;
            if (rx_idx_q == LAST_IDX) begin
              rx_state_d = STOP;
            end else begin
              rx_idx_d = rx_idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (rx_tick) begin
            rx_state_d = IDLE;
            if (w_rx_bit) begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
            end else if (rx_shift_q == '0) begin
              rx_break_d = 1'b1;
            end
          end
        end
        default: rx_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_break_q <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], bus.uart_rxd};
      rx_prev_q  <= w_rx_bit;
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_break_q <= rx_break_d;
    end
  end

  assign bus.uart_rx_valid = rx_valid_q;
  assign bus.uart_rx_break = rx_break_q;
  assign bus.uart_rx_data  = rx_data_q;

  // ---------------- transmit path ----------------
  uart_state_t             tx_state_q, tx_state_d;
  logic [IDX_W-1:0]        tx_idx_q, tx_idx_d;
  logic [STOP_W-1:0]       tx_stop_q, tx_stop_d;
  logic [PAYLOAD_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                    txd_q, txd_d;
  logic                    tx_load_full, tx_tick;

  uart_bit_timer #(.CYCLES(CYCLES_PER_BIT), .HALF(HALF_BIT)) u_tx_timer (
    .clk1        (clk1),
    .rst         (rst),
    .load_half_i (1'b0),
    .load_full_i (tx_load_full),
    .tick_o      (tx_tick)
  );

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_idx_d     = tx_idx_q;
    tx_stop_d    = tx_stop_q;
    tx_shift_d   = tx_shift_q;
    txd_d        = txd_q;
    tx_load_full = 1'b0;
    case (tx_state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (bus.uart_tx_en) begin
          tx_state_d   = START;
          tx_shift_d   = bus.uart_tx_data;
          tx_idx_d     = '0;
          tx_stop_d    = '0;
          txd_d        = 1'b0;
          tx_load_full = 1'b1;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_state_d   = DATA;
          txd_d        = tx_shift_q[0];
          tx_shift_d   = tx_shift_q >> 1;
          tx_load_full = 1'b1;
        end
      end
      DATA: begin
        if (tx_tick) begin
          tx_load_full = 1'b1;
          if (tx_idx_q == LAST_IDX) begin
            tx_state_d = STOP;
            txd_d      = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (tx_tick) begin
          if (tx_stop_q == LAST_STOP) begin
            tx_state_d = IDLE;
          end else begin
            tx_stop_d    = tx_stop_q + 1'b1;
            tx_load_full = 1'b1;
          end
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_idx_q   <= '0;
      tx_stop_q  <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign bus.uart_txd     = txd_q;
  assign bus.uart_tx_busy = (tx_state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_transceiver.sv
// ============================================================================
// Module : tb_uart_transceiver
// Brief  : Self-checking bench for uart_transceiver at a short bit period.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_transceiver;

  localparam int CLK_HZ   = 1700000;
  localparam int BIT_RATE = 100000;
  localparam int N        = CLK_HZ / BIT_RATE;   // 17 cycles per bit
  localparam int H        = N / 2;               // 8

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic rxd_drv = 1'b1;
  logic loop_en = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   brk_n = 0;
  int   exp_brk = 0;

  logic [7:0] rxq[$];
  int         rxt[$];
  logic [7:0] exp_rx[$];

  uart_transceiver_if #(.PAYLOAD_BITS(8)) bus ();

  assign bus.uart_rxd = loop_en ? bus.uart_txd : rxd_drv;

  uart_transceiver #(
    .CLK_HZ       (CLK_HZ),
    .BIT_RATE     (BIT_RATE),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1)
  ) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  always @(negedge clk1) begin
    if (bus.uart_rx_valid) begin
      rxq.push_back(bus.uart_rx_data);
      rxt.push_back(cyc);
    end
    if (bus.uart_rx_break) brk_n <= brk_n + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_cnt"}, rxq.size(), exp_rx.size());
    while (rxq.size() > 0 && exp_rx.size() > 0)
      check({tag, "_data"}, rxq.pop_front(), exp_rx.pop_front());
    check({tag, "_brk"}, brk_n, exp_brk);
    rxq.delete();
    rxt.delete();
    exp_rx.delete();
  endtask

  // Serial frame as seen on the wire: start, data LSB first, stop
  function automatic logic [9:0] frame_of(input logic [7:0] b, input logic stopb);
    return {stopb, b, 1'b0};
  endfunction

  task automatic drive_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = frame_of(b, stopb);
    for (int k = 0; k < 10; k++) begin
      rxd_drv = f[k];
      repeat (N) @(negedge clk1);
    end
    rxd_drv = 1'b1;
    if (stopb) exp_rx.push_back(b);
  endtask

  // Called at a negedge with the transmitter idle; returns one cycle after the frame
  task automatic send_tx(input logic [7:0] b, input bit inject);
    logic [9:0] f;
    int dev, bdev;
    logic mid;
    f = frame_of(b, 1'b1);
    bus.uart_tx_data = b;
    bus.uart_tx_en   = 1'b1;
    @(negedge clk1);
    bus.uart_tx_en   = 1'b0;
    bus.uart_tx_data = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      dev = 0; bdev = 0; mid = 1'bx;
      for (int c = 0; c < N; c++) begin
        if (bus.uart_txd !== f[k]) dev++;
        if (bus.uart_tx_busy !== 1'b1) bdev++;
        if (c == N / 2) mid = bus.uart_txd;
        if (inject && k == 4 && c == 0) begin
          bus.uart_tx_en   = 1'b1;
          bus.uart_tx_data = 8'h00;
        end else begin
          bus.uart_tx_en = 1'b0;
        end
        @(negedge clk1);
      end
      check("tx_bit", {31'd0, mid}, {31'd0, f[k]});
      check("tx_bit_stable", dev, 0);
      check("tx_busy_frame", bdev, 0);
    end
    check("tx_busy_end", {31'd0, bus.uart_tx_busy}, 32'd0);
    check("tx_txd_end", {31'd0, bus.uart_txd}, 32'd1);
  endtask

  initial begin
    logic [7:0] b, b2;
    logic [7:0] lb[4];
    logic [9:0] f;
    int dev, t0;

    bus.uart_rx_en   = 1'b1;
    bus.uart_tx_en   = 1'b0;
    bus.uart_tx_data = 8'h00;
    repeat (3) @(negedge clk1);
    rst = 1'b0;

    check("rst_txd", {31'd0, bus.uart_txd}, 32'd1);
    check("rst_busy", {31'd0, bus.uart_tx_busy}, 32'd0);
    check("rst_valid", {31'd0, bus.uart_rx_valid}, 32'd0);
    check("rst_break", {31'd0, bus.uart_rx_break}, 32'd0);
    check("rst_rx_data", {24'd0, bus.uart_rx_data}, 32'd0);

    dev = 0;
    repeat (5000) begin
      @(negedge clk1);
      if (bus.uart_txd !== 1'b1 || bus.uart_tx_busy !== 1'b0) dev++;
    end
    check("idle_tx_dev", dev, 0);
    compare_rx("idle");

    // Single 0x31 frame with latency window from the start edge
    t0 = cyc;
    drive_rx(8'h31, 1'b1);
    repeat (2 * N) @(negedge clk1);
    if (rxt.size() > 0) begin
      check("rx31_latency_ok", {31'd0, (rxt[0] - t0 >= H + 9 * N) && (rxt[0] - t0 <= H + 9 * N + 4)}, 32'd1);
    end
    check("rx31_held", {24'd0, bus.uart_rx_data}, 32'h31);
    compare_rx("rx31");

    for (int i = 0; i < 6; i++) begin
      drive_rx(8'($urandom), 1'b1);
      repeat ($urandom_range(0, N)) @(negedge clk1);
    end
    repeat (2 * N) @(negedge clk1);
    compare_rx("rx_rand");

    send_tx(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) send_tx(8'($urandom), 1'b0);

    // Full duplex: independent bytes on each direction at once
    b = 8'($urandom);
    b2 = 8'($urandom);
    fork
      send_tx(b, 1'b0);
      drive_rx(b2, 1'b1);
    join
    repeat (2 * N) @(negedge clk1);
    compare_rx("duplex");

    loop_en = 1'b1;
    lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hFF; lb[3] = 8'h37;
    for (int i = 0; i < 4; i++) begin
      send_tx(lb[i], 1'b0);
      exp_rx.push_back(lb[i]);
    end
    repeat (2 * N) @(negedge clk1);
    loop_en = 1'b0;
    compare_rx("loopback");

    rxd_drv = 1'b0;
    repeat (12 * N) @(negedge clk1);
    rxd_drv = 1'b1;
    exp_brk++;
    repeat (3 * N) @(negedge clk1);
    check("break_data_held", {24'd0, bus.uart_rx_data}, 32'h37);
    compare_rx("break");

    rxd_drv = 1'b0;
    repeat (3) @(negedge clk1);
    rxd_drv = 1'b1;
    repeat (12 * N) @(negedge clk1);
    compare_rx("glitch");
    drive_rx(8'($urandom), 1'b1);
    repeat (2 * N) @(negedge clk1);
    compare_rx("post_glitch");

    drive_rx(8'h5A, 1'b0);
    repeat (3 * N) @(negedge clk1);
    compare_rx("framing_err");

    bus.uart_rx_en = 1'b0;
    drive_rx(8'h66, 1'b1);
    exp_rx.delete();
    repeat (2 * N) @(negedge clk1);
    bus.uart_rx_en = 1'b1;
    compare_rx("rx_disabled");

    // Reset during simultaneous TX and RX frames
    f = frame_of(8'h7E, 1'b1);
    bus.uart_tx_en   = 1'b1;
    bus.uart_tx_data = 8'($urandom);
    for (int c = 0; c < 4 * N; c++) begin
      rxd_drv = f[c / N];
      @(negedge clk1);
      bus.uart_tx_en = 1'b0;
    end
    rst = 1'b1;
    rxd_drv = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    check("midrst_txd", {31'd0, bus.uart_txd}, 32'd1);
    check("midrst_busy", {31'd0, bus.uart_tx_busy}, 32'd0);
    repeat (12 * N) @(negedge clk1);
    check("midrst_rx_data", {24'd0, bus.uart_rx_data}, 32'd0);
    check("midrst_txd_idle", {31'd0, bus.uart_txd}, 32'd1);
    compare_rx("midrst");
    drive_rx(8'h42, 1'b1);
    repeat (2 * N) @(negedge clk1);
    compare_rx("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
